cpu_scan: RTL and testbench

- 8-bit accumulator "adding machine" CPU with full-scan insertion.
- Has 6-bit memory address bus and separate 8-bit data in/out buses.
- All 26 state flip-flops form one scan chain controlled by NbarT (1 = test/shift, 0 = normal).
- Used as the device-under-test for stuck-at fault simulation with scan-based test vectors.

---
 rtl/cpu_scan.sv | 112 +++++++++++
 tb/tb_cpu_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_scan.sv
// 8-bit accumulator CPU with a full 26-flop scan chain.
// Chain layout (LSB first): PC[5:0], AC[7:0], IR[7:0], ST[3:0]; so taps the ST MSB.
module cpu_scan (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       reset,
  input  logic [7:0] data_bus_in,
  input  logic       si,
  input  logic       NbarT,
  output logic [5:0] adr_bus,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic [7:0] data_bus_out,
  output logic       so
);

  typedef enum logic [3:0] {
    StIdle   = 4'b0000,
    StFetch  = 4'b0001,
    StDecode = 4'b0010,
    StExec   = 4'b0011
  } state_e;

  localparam logic [1:0] OpLda = 2'b00;
  localparam logic [1:0] OpSta = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpJmp = 2'b11;

  logic [5:0]  pc_q, pc_d;
  logic [7:0]  ac_q, ac_d;
  logic [7:0]  ir_q, ir_d;
  state_e      st_q, st_d;
  logic [25:0] chain;
  logic [25:0] chain_shift;

  assign chain        = {st_q, ir_q, ac_q, pc_q};
  assign chain_shift  = {chain[24:0], si};
  assign so           = chain[25];
  assign data_bus_out = ac_q;

  // Functional next state and Moore outputs; illegal states fall to the defaults.
  always_comb begin
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    st_d    = StIdle;
    adr_bus = pc_q;
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    case (st_q)
      StIdle: begin
        st_d = StFetch;
      end
      StFetch: begin
        rd_mem = 1'b1;
        ir_d   = data_bus_in;
        pc_d   = pc_q + 6'd1;
        st_d   = StDecode;
      end
      StDecode: begin
        adr_bus = ir_q[5:0];
        st_d    = StExec;
      end
      StExec: begin
        adr_bus = ir_q[5:0];
        st_d    = StFetch;
        case (ir_q[7:6])
          OpLda: begin
            rd_mem = 1'b1;
            ac_d   = data_bus_in;
          end
          OpSta: begin
            wr_mem = 1'b1;
          end
          OpAdd: begin
            rd_mem = 1'b1;
            ac_d   = ac_q + data_bus_in;
          end
          OpJmp: begin
            pc_d = ir_q[5:0];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State register: global reset, then partial reset, then scan shift, then capture.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      pc_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      st_q <= StIdle;
    end else if (reset) begin
      pc_q <= '0;
      st_q <= StIdle;
    end else if (NbarT) begin
      pc_q <= chain_shift[5:0];
      ac_q <= chain_shift[13:6];
      ir_q <= chain_shift[21:14];
      st_q <= state_e'(chain_shift[25:22]);
    end else begin
      pc_q <= pc_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      st_q <= st_d;
    end
  end

endmodule

// File: tb/tb_cpu_scan.sv
// Directed self-checking bench for cpu_scan: scan load/unload plus single capture cycles.
module tb_cpu_scan;

  logic       clk;
  logic       global_reset;
  logic       reset;
  logic [7:0] data_bus_in;
  logic       si;
  logic       NbarT;
  logic [5:0] adr_bus;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] data_bus_out;
  logic       so;

  int checks = 0;
  int errors = 0;

  cpu_scan dut (
    .clk          (clk),
    .global_reset (global_reset),
    .reset        (reset),
    .data_bus_in  (data_bus_in),
    .si           (si),
    .NbarT        (NbarT),
    .adr_bus      (adr_bus),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .data_bus_out (data_bus_out),
    .so           (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] ch(input logic [3:0] st, input logic [7:0] ir,
                                     input logic [7:0] ac, input logic [5:0] pc);
    return {st, ir, ac, pc};
  endfunction

  // 26 shifts: load vin (MSB first) while collecting the old chain (chain[25] first).
  task automatic scan(input logic [25:0] vin, output logic [25:0] vout);
    vout  = '0;
    NbarT = 1'b1;
    for (int i = 25; i >= 0; i--) begin
      si   = vin[i];
      vout = {vout[24:0], so};
      tick();
    end
    NbarT = 1'b0;
    si    = 1'b0;
  endtask

  initial begin
    logic [25:0] u;
    global_reset = 1'b1;
    reset        = 1'b0;
    NbarT        = 1'b0;
    si           = 1'b0;
    data_bus_in  = 8'h00;
    tick();
    global_reset = 1'b0;

    // Reset state
    check("rst_adr", 32'(adr_bus), 32'h0);
    check("rst_rd", 32'(rd_mem), 32'h0);
    check("rst_wr", 32'(wr_mem), 32'h0);
    check("rst_dbo", 32'(data_bus_out), 32'h0);
    check("rst_so", 32'(so), 32'h0);
    scan(ch(4'h1, 8'h12, 8'h5A, 6'h05), u);
    check("rst_chain", 32'(u), 32'h0);

    // Partial reset keeps AC and IR
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("prst_dbo", 32'(data_bus_out), 32'h5A);
    check("prst_adr", 32'(adr_bus), 32'h0);
    check("prst_rd", 32'(rd_mem), 32'h0);
    scan(ch(4'h0, 8'h00, 8'h00, 6'h00), u);
    check("prst_chain", 32'(u), 32'(ch(4'h0, 8'h12, 8'h5A, 6'h00)));

    // Fetch + LDA 10
    tick();
    check("fetch_rd", 32'(rd_mem), 32'h1);
    check("fetch_wr", 32'(wr_mem), 32'h0);
    check("fetch_adr", 32'(adr_bus), 32'h0);
    data_bus_in = 8'h0A;
    tick();
    check("dec_adr", 32'(adr_bus), 32'd10);
    check("dec_strb", 32'({rd_mem, wr_mem}), 32'h0);
    tick();
    check("lda_adr", 32'(adr_bus), 32'd10);
    check("lda_rd", 32'(rd_mem), 32'h1);
    data_bus_in = 8'h33;
    tick();
    check("lda_ac", 32'(data_bus_out), 32'h33);
    check("lda_next_adr", 32'(adr_bus), 32'h1);
    check("lda_next_rd", 32'(rd_mem), 32'h1);
    scan(ch(4'h3, 8'h85, 8'hF0, 6'h09), u);
    check("lda_chain", 32'(u), 32'(ch(4'h1, 8'h0A, 8'h33, 6'h01)));

    // ADD with carry out discarded
    check("add_adr", 32'(adr_bus), 32'd5);
    check("add_rd", 32'(rd_mem), 32'h1);
    data_bus_in = 8'h20;
    tick();
    check("add_ac", 32'(data_bus_out), 32'h10);
    check("add_next_adr", 32'(adr_bus), 32'h09);
    scan(ch(4'h3, 8'h47, 8'hC3, 6'h02), u);
    check("add_chain", 32'(u), 32'(ch(4'h1, 8'h85, 8'h10, 6'h09)));

    // STA 7: AC must not be loaded from the bus
    data_bus_in = 8'h99;
    check("sta_wr", 32'(wr_mem), 32'h1);
    check("sta_rd", 32'(rd_mem), 32'h0);
    check("sta_adr", 32'(adr_bus), 32'd7);
    check("sta_dbo", 32'(data_bus_out), 32'hC3);
    tick();
    scan(ch(4'h3, 8'hFF, 8'h11, 6'h04), u);
    check("sta_chain", 32'(u), 32'(ch(4'h1, 8'h47, 8'hC3, 6'h02)));

    // JMP 63, then fetch at 63 wraps PC to 0
    check("jmp_strb", 32'({rd_mem, wr_mem}), 32'h0);
    check("jmp_adr", 32'(adr_bus), 32'd63);
    tick();
    check("jmp_fetch_adr", 32'(adr_bus), 32'd63);
    check("jmp_fetch_rd", 32'(rd_mem), 32'h1);
    data_bus_in = 8'h00;
    tick();
    scan(26'h2AAAAAA, u);
    check("wrap_chain", 32'(u), 32'(ch(4'h2, 8'h00, 8'h11, 6'h00)));

    // Alternating pattern lands ST=1010 (illegal); one capture goes to IDLE
    check("pat_adr", 32'(adr_bus), 32'h2A);
    check("pat_strb", 32'({rd_mem, wr_mem}), 32'h0);
    tick();
    scan(ch(4'hF, 8'h3C, 8'h77, 6'h15), u);
    check("pat_chain", 32'(u), 32'h02AAAAA);

    // Illegal 1111 captures to IDLE, others hold
    check("ill_adr", 32'(adr_bus), 32'h15);
    check("ill_strb", 32'({rd_mem, wr_mem}), 32'h0);
    tick();
    scan(ch(4'h2, 8'h8A, 8'h01, 6'h03), u);
    check("ill_chain", 32'(u), 32'(ch(4'h0, 8'h3C, 8'h77, 6'h15)));

    // Exactly one transition per capture: DECODE -> EXEC
    tick();
    scan(ch(4'h1, 8'hAB, 8'hCD, 6'h3F), u);
    check("step_chain", 32'(u), 32'(ch(4'h3, 8'h8A, 8'h01, 6'h03)));

    // global_reset overrides scan shift
    NbarT        = 1'b1;
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    NbarT        = 1'b0;
    scan(26'h0, u);
    check("gr_scan_chain", 32'(u), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
